// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file with write-through bypass, immediate extension,
// operand/destination select, load-use hazard detection and the ID/EXE pipeline register.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int IMM_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instr_valid,
    input  logic [31:0]               instruction,
    input  logic [DATA_W-1:0]         pc,
    input  logic                      ctl_is_imm,
    input  logic                      ctl_mem_read,
    input  logic                      ctl_mem_write,
    input  logic                      ctl_wb_en,
    input  logic [3:0]                ctl_exe_cmd,
    input  logic [1:0]                ctl_br_type,
    input  logic                      wb_en,
    input  logic [$clog2(NREGS)-1:0]  wb_dest,
    input  logic [DATA_W-1:0]         wb_result,
    input  logic                      exe_valid,
    input  logic                      exe_mem_read,
    input  logic [$clog2(NREGS)-1:0]  exe_dest,
    input  logic                      flush,
    output logic                      stall,
    output logic                      idexe_valid,
    output logic                      idexe_mem_read,
    output logic                      idexe_mem_write,
    output logic                      idexe_wb_en,
    output logic [3:0]                idexe_exe_cmd,
    output logic [1:0]                idexe_br_type,
    output logic [DATA_W-1:0]         idexe_alu1,
    output logic [DATA_W-1:0]         idexe_alu2,
    output logic [DATA_W-1:0]         idexe_reg2,
    output logic [DATA_W-1:0]         idexe_pc,
    output logic [$clog2(NREGS)-1:0]  idexe_dest,
    output logic [$clog2(NREGS)-1:0]  idexe_src1,
    output logic [$clog2(NREGS)-1:0]  idexe_src2
);
    localparam int AW = $clog2(NREGS);

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              mem_write;
        logic              wb_en;
        logic [3:0]        exe_cmd;
        logic [1:0]        br_type;
        logic [DATA_W-1:0] alu1;
        logic [DATA_W-1:0] alu2;
        logic [DATA_W-1:0] reg2;
        logic [DATA_W-1:0] pc;
        logic [AW-1:0]     dest;
        logic [AW-1:0]     src1;
        logic [AW-1:0]     src2;
    } idexe_t;

    logic [AW-1:0]     src1;
    logic [AW-1:0]     src2;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rf [NREGS];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              uses_src2;
    logic              hz;
    idexe_t            idexe_next;
    idexe_t            idexe_reg;
    logic              unused_bits;

    assign src1 = instruction[21 +: AW];
    assign src2 = instruction[16 +: AW];
    assign rd   = instruction[11 +: AW];
    assign imm  = DATA_W'($signed(instruction[IMM_W-1:0]));
    assign unused_bits = ^instruction;

    // Register 0 is a hard-wired zero; the rest are plain flops cleared by reset.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] q_reg;
                always_ff @(posedge clock) begin
                    if (reset) begin
                        q_reg <= '0;
                    end else if (wb_en && wb_dest == AW'(gi)) begin
                        q_reg <= wb_result;
                    end
                end
                assign rf[gi] = q_reg;
            end
        end
    endgenerate

    // Write-through: a same-cycle writeback to a non-zero source wins over the stored value.
    assign rd1 = (wb_en && wb_dest == src1 && src1 != '0) ? wb_result : rf[src1];
    assign rd2 = (wb_en && wb_dest == src2 && src2 != '0) ? wb_result : rf[src2];

    assign uses_src2 = !ctl_is_imm || ctl_mem_write;
    assign hz = instr_valid && exe_valid && exe_mem_read && exe_dest != '0 &&
                (exe_dest == src1 || (uses_src2 && exe_dest == src2));
    assign stall = hz && !flush;

    always_comb begin
        idexe_next           = '0;
        idexe_next.valid     = instr_valid;
        idexe_next.mem_read  = instr_valid && ctl_mem_read;
        idexe_next.mem_write = instr_valid && ctl_mem_write;
        idexe_next.wb_en     = instr_valid && ctl_wb_en;
        idexe_next.br_type   = instr_valid ? ctl_br_type : 2'b00;
        idexe_next.exe_cmd   = ctl_exe_cmd;
        idexe_next.alu1      = rd1;
        idexe_next.alu2      = ctl_is_imm ? imm : rd2;
        idexe_next.reg2      = rd2;
        idexe_next.pc        = pc;
        idexe_next.dest      = ctl_is_imm ? src2 : rd;
        idexe_next.src1      = src1;
        idexe_next.src2      = src2;
    end

    // A bubble is simply an all-zero ID/EXE word, so flush and hazard share the reset path.
    always_ff @(posedge clock) begin
        if (reset || flush || hz) begin
            idexe_reg <= '0;
        end else begin
            idexe_reg <= idexe_next;
        end
    end

    assign idexe_valid     = idexe_reg.valid;
    assign idexe_mem_read  = idexe_reg.mem_read;
    assign idexe_mem_write = idexe_reg.mem_write;
    assign idexe_wb_en     = idexe_reg.wb_en;
    assign idexe_exe_cmd   = idexe_reg.exe_cmd;
    assign idexe_br_type   = idexe_reg.br_type;
    assign idexe_alu1      = idexe_reg.alu1;
    assign idexe_alu2      = idexe_reg.alu2;
    assign idexe_reg2      = idexe_reg.reg2;
    assign idexe_pc        = idexe_reg.pc;
    assign idexe_dest      = idexe_reg.dest;
    assign idexe_src1      = idexe_reg.src1;
    assign idexe_src2      = idexe_reg.src2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed cases followed by random traffic
// compared against an array-based behavioural model of the decode stage.
module tb_id_stage_pipe;
    logic        clock = 1'b0;
    logic        reset, instr_valid;
    logic [31:0] instruction, pc;
    logic        ctl_is_imm, ctl_mem_read, ctl_mem_write, ctl_wb_en;
    logic [3:0]  ctl_exe_cmd;
    logic [1:0]  ctl_br_type;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_result;
    logic        exe_valid, exe_mem_read;
    logic [4:0]  exe_dest;
    logic        flush;
    logic        stall;
    logic        idexe_valid, idexe_mem_read, idexe_mem_write, idexe_wb_en;
    logic [3:0]  idexe_exe_cmd;
    logic [1:0]  idexe_br_type;
    logic [31:0] idexe_alu1, idexe_alu2, idexe_reg2, idexe_pc;
    logic [4:0]  idexe_dest, idexe_src1, idexe_src2;

    always #5 clock = ~clock;

    id_stage_pipe dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
        .pc(pc), .ctl_is_imm(ctl_is_imm), .ctl_mem_read(ctl_mem_read),
        .ctl_mem_write(ctl_mem_write), .ctl_wb_en(ctl_wb_en), .ctl_exe_cmd(ctl_exe_cmd),
        .ctl_br_type(ctl_br_type), .wb_en(wb_en), .wb_dest(wb_dest), .wb_result(wb_result),
        .exe_valid(exe_valid), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
        .flush(flush), .stall(stall), .idexe_valid(idexe_valid),
        .idexe_mem_read(idexe_mem_read), .idexe_mem_write(idexe_mem_write),
        .idexe_wb_en(idexe_wb_en), .idexe_exe_cmd(idexe_exe_cmd),
        .idexe_br_type(idexe_br_type), .idexe_alu1(idexe_alu1), .idexe_alu2(idexe_alu2),
        .idexe_reg2(idexe_reg2), .idexe_pc(idexe_pc), .idexe_dest(idexe_dest),
        .idexe_src1(idexe_src1), .idexe_src2(idexe_src2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference register file and the expected ID/EXE contents after the next edge.
    logic [31:0] mrf [32];
    logic        e_valid, e_mem_read, e_mem_write, e_wb_en;
    logic [3:0]  e_exe_cmd;
    logic [1:0]  e_br_type;
    logic [31:0] e_alu1, e_alu2, e_reg2, e_pc;
    logic [4:0]  e_dest, e_src1, e_src2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_dest == idx) return wb_result;
        return mrf[idx];
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        return {6'd0, s1, s2, d, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] s1, input logic [4:0] rt, input logic [15:0] im);
        return {6'd0, s1, rt, im};
    endfunction

    task automatic idle();
        reset = 0; instr_valid = 0; instruction = 0; pc = 0;
        ctl_is_imm = 0; ctl_mem_read = 0; ctl_mem_write = 0; ctl_wb_en = 0;
        ctl_exe_cmd = 0; ctl_br_type = 0; wb_en = 0; wb_dest = 0; wb_result = 0;
        exe_valid = 0; exe_mem_read = 0; exe_dest = 0; flush = 0;
    endtask

    // One clock: check stall against the rules, predict the register, advance, compare.
    task automatic step();
        logic [4:0] s1, s2;
        logic       uses2, hz;
        #1;
        s1 = instruction[25:21];
        s2 = instruction[20:16];
        uses2 = !ctl_is_imm || ctl_mem_write;
        hz = instr_valid && exe_valid && exe_mem_read && exe_dest != 0 &&
             (exe_dest == s1 || (uses2 && exe_dest == s2));
        check("stall", stall, hz && !flush);
        if (reset || flush || hz) begin
            {e_valid, e_mem_read, e_mem_write, e_wb_en, e_exe_cmd, e_br_type} = '0;
            {e_alu1, e_alu2, e_reg2, e_pc, e_dest, e_src1, e_src2} = '0;
        end else begin
            e_valid     = instr_valid;
            e_mem_read  = instr_valid ? ctl_mem_read : 1'b0;
            e_mem_write = instr_valid ? ctl_mem_write : 1'b0;
            e_wb_en     = instr_valid ? ctl_wb_en : 1'b0;
            e_br_type   = instr_valid ? ctl_br_type : 2'd0;
            e_exe_cmd   = ctl_exe_cmd;
            e_alu1      = model_read(s1);
            e_reg2      = model_read(s2);
            e_alu2      = ctl_is_imm ? {{16{instruction[15]}}, instruction[15:0]} : e_reg2;
            e_dest      = ctl_is_imm ? s2 : instruction[15:11];
            e_pc        = pc;
            e_src1      = s1;
            e_src2      = s2;
        end
        if (reset) begin
            for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        end else if (wb_en && wb_dest != 0) begin
            mrf[wb_dest] = wb_result;
        end
        @(posedge clock);
        #1;
        check("valid", idexe_valid, e_valid);
        check("mem_read", idexe_mem_read, e_mem_read);
        check("mem_write", idexe_mem_write, e_mem_write);
        check("wb_en", idexe_wb_en, e_wb_en);
        check("exe_cmd", idexe_exe_cmd, e_exe_cmd);
        check("br_type", idexe_br_type, e_br_type);
        check("alu1", idexe_alu1, e_alu1);
        check("alu2", idexe_alu2, e_alu2);
        check("reg2", idexe_reg2, e_reg2);
        check("pc", idexe_pc, e_pc);
        check("dest", idexe_dest, e_dest);
        check("src1", idexe_src1, e_src1);
        check("src2", idexe_src2, e_src2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        idle();
        reset = 1;
        step();
        $display("reset: valid=%0d alu1=%0h", idexe_valid, idexe_alu1);

        // Reset clears a register even while a writeback targets it.
        idle(); wb_en = 1; wb_dest = 3; wb_result = 32'h55;
        step();
        reset = 1; wb_result = 32'h99;
        step();
        idle(); instr_valid = 1; instruction = mk_r(3, 0, 1);
        step();
        check("rst_rf3", idexe_alu1, 32'd0);
        $display("reset rf[3]: alu1=%0h", idexe_alu1);

        idle(); wb_en = 1; wb_dest = 5; wb_result = 32'hDEADBEEF;
        instr_valid = 1; instruction = mk_r(5, 0, 2); ctl_wb_en = 1;
        step();
        check("bypass_alu1", idexe_alu1, 32'hDEADBEEF);
        $display("bypass: alu1=%0h", idexe_alu1);

        idle(); wb_en = 1; wb_dest = 0; wb_result = 32'h1234;
        instr_valid = 1; instruction = mk_r(0, 0, 2);
        step();
        check("r0_bypass", idexe_alu1, 32'd0);
        idle(); instr_valid = 1; instruction = mk_r(0, 0, 2);
        step();
        check("r0_read", idexe_alu1, 32'd0);
        $display("reg0: alu1=%0h", idexe_alu1);

        idle(); instr_valid = 1; ctl_is_imm = 1; ctl_wb_en = 1; instruction = mk_i(1, 7, 16'h8000);
        step();
        check("imm_alu2", idexe_alu2, 32'hFFFF8000);
        check("imm_dest", idexe_dest, 5'd7);
        $display("imm: alu2=%0h dest=%0d", idexe_alu2, idexe_dest);

        idle(); instr_valid = 1; ctl_wb_en = 1; instruction = mk_r(1, 4, 9);
        exe_valid = 1; exe_mem_read = 1; exe_dest = 4;
        #1 check("lu_stall", stall, 1'b1);
        step();
        check("lu_bubble", idexe_valid, 1'b0);
        exe_valid = 0;
        #1 check("lu_release", stall, 1'b0);
        step();
        check("lu_issue", idexe_valid, 1'b1);
        $display("load-use: issued valid=%0d", idexe_valid);

        idle(); instr_valid = 1; ctl_is_imm = 1; ctl_mem_read = 1; instruction = mk_i(1, 4, 16'h0010);
        exe_valid = 1; exe_mem_read = 1; exe_dest = 4;
        #1 check("imm_nostall", stall, 1'b0);
        step();
        $display("imm no-stall: valid=%0d", idexe_valid);

        idle(); instr_valid = 1; ctl_wb_en = 1; ctl_mem_write = 1; instruction = mk_r(1, 4, 9);
        exe_valid = 1; exe_mem_read = 1; exe_dest = 4; flush = 1;
        #1 check("flush_stall", stall, 1'b0);
        step();
        check("flush_wb", idexe_wb_en, 1'b0);
        check("flush_mw", idexe_mem_write, 1'b0);
        $display("flush: valid=%0d wb_en=%0d", idexe_valid, idexe_wb_en);

        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 39) == 0);
            instr_valid   = ($urandom_range(0, 3) != 0);
            instruction   = $urandom;
            instruction[25:21] = 5'($urandom_range(0, 7));
            instruction[20:16] = 5'($urandom_range(0, 7));
            pc            = $urandom;
            ctl_is_imm    = $urandom_range(0, 1);
            ctl_mem_read  = $urandom_range(0, 1);
            ctl_mem_write = $urandom_range(0, 1);
            ctl_wb_en     = $urandom_range(0, 1);
            ctl_exe_cmd   = 4'($urandom);
            ctl_br_type   = 2'($urandom);
            wb_en         = $urandom_range(0, 1);
            wb_dest       = 5'($urandom_range(0, 7));
            wb_result     = $urandom;
            exe_valid     = $urandom_range(0, 1);
            exe_mem_read  = ($urandom_range(0, 2) != 0);
            exe_dest      = 5'($urandom_range(0, 7));
            flush         = ($urandom_range(0, 7) == 0);
            step();
            $display("rand %0d: stall=%0d valid=%0d alu1=%0h alu2=%0h", n, stall, idexe_valid,
                     idexe_alu1, idexe_alu2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
